axi4_lite_read_slave_responder: RTL and testbench
=================================================

AXI4_LITE_READ_SLAVE_RESPONDER -- requirements
Module: axi4_lite_read_slave_responder

Interface
REQ-001 SHALL have parameters: ADDRESS_WIDTH, default 32, AR address width; DATA_WIDTH, default 32, R data width; DELAY_WIDTH, default 5, delay field width; MIN_ADDRESS, default 8'h01, lowest legal address; MAX_ADDRESS, default 8'hff, highest legal address; DEFAULT_READY, default 1, idle level of arready.
REQ-002 SHALL have one clock and a synchronous, active-high reset:
- aclk  in  1  clock; all logic on its rising edge
- areset  in  1  synchronous reset, active-high
REQ-003 SHALL have these ports:
- araddr  in  ADDRESS_WIDTH  read address
- arprot  in  3  protection type; accepted, ignored
- arvalid  in  1  address valid
- arready  out  1  address ready
- rdata  out  DATA_WIDTH  read data
- rresp  out  2  response: 00 OKAY, 10 SLVERR
- rvalid  out  1  data valid
- rready  in  1  data ready
- cfg_rvalid_delay  in  DELAY_WIDTH  cycles from AR handshake to rvalid
- load_en  in  1  backdoor word write strobe
- load_addr  in  6  backdoor word index
- load_data  in  DATA_WIDTH  backdoor write data
- read_count  out  16  completed R handshakes
- timeout_err  out  1  sticky rready-timeout flag

Function
REQ-004 SHALL hold 64 words of DATA_WIDTH, indexed by araddr[7:2]; load_en writes load_data to word load_addr at the clock edge.
REQ-005 SHALL use an FSM with states IDLE, DELAY and RESP, and SHALL allow only one outstanding read.
REQ-006 When DEFAULT_READY=1, arready SHALL be 1 in IDLE and 0 in all other states.
REQ-007 When DEFAULT_READY=0, arready SHALL be 0 by default; in IDLE with arvalid=1 it SHALL rise the next cycle for exactly one cycle.
REQ-008 An AR handshake (arvalid&arready) SHALL capture araddr, cfg_rvalid_delay, rresp and rdata in the same cycle.
REQ-009 rresp SHALL be SLVERR with rdata=0 when araddr<MIN_ADDRESS, araddr>MAX_ADDRESS, or araddr[1:0]!=0; otherwise rresp SHALL be OKAY with rdata = word[araddr[7:2]].
REQ-010 If load_en writes the word being read in the handshake cycle, the read SHALL return the old value.
REQ-011 After a handshake: a captured delay of 0 SHALL go to RESP with rvalid=1 the next cycle; a delay N>0 SHALL go to DELAY and assert rvalid exactly N+1 cycles after the handshake.
REQ-012 In RESP, rvalid, rdata and rresp SHALL stay stable until rvalid&rready; the FSM SHALL then return to IDLE and rvalid SHALL drop the next cycle.
REQ-013 Loads after the handshake SHALL NOT alter rdata for the pending read.
REQ-014 read_count SHALL increment by 1 on each R handshake and SHALL wrap from 16'hffff to 0.
REQ-015 arvalid asserted outside IDLE SHALL NOT be accepted until the FSM returns to IDLE.

Reset
REQ-016 areset SHALL force state=IDLE, rvalid=0, rdata=0, rresp=OKAY, read_count=0 and timeout_err=0, and SHALL set arready to DEFAULT_READY (0 in the reset cycle when DEFAULT_READY=0).
REQ-017 Reset during DELAY or RESP SHALL abandon the pending read with no R handshake; word contents SHALL NOT be cleared by reset.

Configuration
REQ-018 Macro AXI4_LITE_READ_SLAVE_TIMEOUT_EN:
- Defined: a 6-bit counter SHALL count consecutive cycles with rvalid=1 and rready=0, and SHALL clear on any R handshake or reset. At count 32 the block SHALL set timeout_err=1, which stays set until reset; the read itself SHALL continue waiting.
- Undefined: the counter SHALL be absent and timeout_err SHALL be tied to 0.

Verification
REQ-019 Load word 4=32'hDEADBEEF, delay=0, read araddr=32'h10 with rready=1: rvalid one cycle after the handshake, rdata=32'hDEADBEEF, rresp=00, read_count=1.
REQ-020 Delay=5, araddr=32'h20: rvalid rises exactly 6 cycles after the handshake; rready held 0 for 3 cycles keeps rdata/rresp stable.
REQ-021 Read araddr=32'h00, then 32'h13, then 32'h100: each returns rresp=10 with rdata=0.
REQ-022 DEFAULT_READY=0: arvalid rises in IDLE; arready is 0 in that cycle, 1 the next cycle for one cycle; a second arvalid during RESP is stalled.
REQ-023 With the macro defined, hold rready=0 for 32 cycles after rvalid: timeout_err=1; a later handshake completes and the flag stays 1. Apply areset in DELAY: rvalid=0 and state=IDLE next cycle.

Source files
------------

// File: rtl/axi4_lite_read_slave_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi4_lite_read_slave_responder                                       |
// | AXI4-Lite read slave over a 64-word array with programmable rvalid   |
// | latency; AXI4_LITE_READ_SLAVE_TIMEOUT_EN adds a sticky rready monitor|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module axi4_lite_read_slave_responder #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       DATA_WIDTH    = 32,
    parameter int                       DELAY_WIDTH   = 5,
    parameter logic [ADDRESS_WIDTH-1:0] MIN_ADDRESS   = 'h01,
    parameter logic [ADDRESS_WIDTH-1:0] MAX_ADDRESS   = 'hff,
    parameter bit                       DEFAULT_READY = 1'b1
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [ADDRESS_WIDTH-1:0] araddr,
    input  logic [2:0]               arprot,
    input  logic                     arvalid,
    output logic                     arready,
    output logic [DATA_WIDTH-1:0]    rdata,
    output logic [1:0]               rresp,
    output logic                     rvalid,
    input  logic                     rready,
    input  logic [DELAY_WIDTH-1:0]   cfg_rvalid_delay,
    input  logic                     load_en,
    input  logic [5:0]               load_addr,
    input  logic [DATA_WIDTH-1:0]    load_data,
    output logic [15:0]              read_count,
    output logic                     timeout_err
);

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [DELAY_WIDTH-1:0] delay_cnt;
    logic [DELAY_WIDTH-1:0] delay_cnt_next;
    logic [DATA_WIDTH-1:0]  mem [0:63];
    logic                   ar_hs;
    logic                   r_hs;
    logic                   addr_err;
    logic                   arprot_unused;

    assign arprot_unused = ^arprot;

    assign ar_hs    = arvalid && arready;
    assign r_hs     = rvalid && rready;
    assign rvalid   = (state == RESP);
    assign addr_err = (araddr < MIN_ADDRESS) || (araddr > MAX_ADDRESS) ||
                      (araddr[1:0] != 2'b00);

    // Array is deliberately outside reset so contents survive it.
    always_ff @(posedge aclk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    always_comb begin
        state_next     = state;
        delay_cnt_next = delay_cnt;
        case (state)
            IDLE: begin
                if (ar_hs) begin
                    if (cfg_rvalid_delay == '0) begin
                        state_next = RESP;
                    end else begin
                        state_next     = DELAY;
                        delay_cnt_next = cfg_rvalid_delay;
                    end
                end
            end
            DELAY: begin
                // A count of N spans N DELAY cycles, so rvalid lands N+1 after the handshake.
                if (delay_cnt == DELAY_WIDTH'(1)) begin
                    state_next = RESP;
                end else begin
                    delay_cnt_next = delay_cnt - DELAY_WIDTH'(1);
                end
            end
            RESP: begin
                if (rready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state      <= IDLE;
            delay_cnt  <= '0;
            rdata      <= '0;
            rresp      <= OKAY;
            read_count <= '0;
        end else begin
            state     <= state_next;
            delay_cnt <= delay_cnt_next;
            if (ar_hs) begin
                rdata <= addr_err ? '0 : mem[araddr[7:2]];
                rresp <= addr_err ? SLVERR : OKAY;
            end
            if (r_hs) begin
                read_count <= read_count + 16'd1;
            end
        end
    end

    generate
        if (DEFAULT_READY) begin : g_ready_idle
            assign arready = (state == IDLE);
        end else begin : g_ready_pulse
            logic ready_pulse;
            always_ff @(posedge aclk) begin
                if (areset) begin
                    ready_pulse <= 1'b0;
                end else begin
                    ready_pulse <= (state == IDLE) && arvalid && !ready_pulse;
                end
            end
            assign arready = ready_pulse;
        end
    endgenerate

`ifdef AXI4_LITE_READ_SLAVE_TIMEOUT_EN
    logic [5:0] stall_cnt;
    logic       timeout_flag;

    // Counter saturates at 32; the flag rises on the same edge the count reaches 32.
    always_ff @(posedge aclk) begin
        if (areset) begin
            stall_cnt    <= '0;
            timeout_flag <= 1'b0;
        end else if (r_hs) begin
            stall_cnt <= '0;
        end else if (rvalid) begin
            if (stall_cnt != 6'd32) begin
                stall_cnt <= stall_cnt + 6'd1;
            end
            if (stall_cnt == 6'd31) begin
                timeout_flag <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_flag;
`else
    assign timeout_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_read_slave_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_axi4_lite_read_slave_responder                                    |
// | Directed bench with a transaction-level reference model.             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_axi4_lite_read_slave_responder;

`ifdef AXI4_LITE_READ_SLAVE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [4:0]  cfg_rvalid_delay;
    logic        load_en;
    logic [5:0]  load_addr;
    logic [31:0] load_data;
    logic [15:0] read_count;
    logic        timeout_err;

    logic        arvalid0;
    logic        arready0;
    logic [31:0] rdata0;
    logic [1:0]  rresp0;
    logic        rvalid0;
    logic        rready0;
    logic [15:0] read_count0;
    logic        timeout_err0;

    int checks   = 0;
    int failures = 0;
    int lat;

    always #5 aclk = ~aclk;

    axi4_lite_read_slave_responder dut (
        .aclk(aclk), .areset(areset), .araddr(araddr), .arprot(arprot),
        .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp),
        .rvalid(rvalid), .rready(rready), .cfg_rvalid_delay(cfg_rvalid_delay),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .read_count(read_count), .timeout_err(timeout_err)
    );

    axi4_lite_read_slave_responder #(.DEFAULT_READY(1'b0)) dut0 (
        .aclk(aclk), .areset(areset), .araddr(araddr), .arprot(arprot),
        .arvalid(arvalid0), .arready(arready0), .rdata(rdata0), .rresp(rresp0),
        .rvalid(rvalid0), .rready(rready0), .cfg_rvalid_delay(cfg_rvalid_delay),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .read_count(read_count0), .timeout_err(timeout_err0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ---------------- reference model (default-ready instance) ----------------
    logic [31:0] m_mem [0:63];
    logic        m_live = 1'b0;
    logic        m_busy = 1'b0;
    longint      m_cyc = 0;
    longint      m_valid_at = 0;
    logic [31:0] m_data = '0;
    logic [1:0]  m_resp = '0;
    logic [15:0] m_cnt = '0;
    int          m_stall = 0;
    logic        m_flag = 1'b0;
    logic        m_err;
    logic        m_rvalid;

    always @(negedge aclk) begin
        m_rvalid = m_busy && (m_cyc >= m_valid_at);
        if (m_live) begin
            chk("model_arready", 32'(arready), 32'(!m_busy));
            chk("model_rvalid", 32'(rvalid), 32'(m_rvalid));
            chk("model_read_count", 32'(read_count), 32'(m_cnt));
            chk("model_timeout_err", 32'(timeout_err), 32'(m_flag));
            if (m_rvalid) begin
                chk("model_rdata", rdata, m_data);
                chk("model_rresp", 32'(rresp), 32'(m_resp));
            end
        end
        if (areset) begin
            m_busy  = 1'b0;
            m_cnt   = '0;
            m_stall = 0;
            m_flag  = 1'b0;
            m_live  = 1'b1;
        end else if (!m_busy) begin
            if (arvalid) begin
                m_err      = (araddr < 32'h01) || (araddr > 32'hff) || (araddr[1:0] != 2'b00);
                m_busy     = 1'b1;
                m_valid_at = m_cyc + longint'(cfg_rvalid_delay) + 1;
                m_data     = m_err ? 32'h0 : m_mem[araddr[7:2]];
                m_resp     = m_err ? 2'b10 : 2'b00;
            end
        end else if (m_rvalid) begin
            if (rready) begin
                m_busy  = 1'b0;
                m_cnt   = m_cnt + 16'd1;
                m_stall = 0;
            end else begin
                if (m_stall < 32) m_stall++;
                if (m_stall == 32 && TO_EN) m_flag = 1'b1;
            end
        end
        if (load_en) m_mem[load_addr] = load_data;
        m_cyc++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic load(input logic [5:0] idx, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = idx;
        load_data = d;
        step();
        load_en = 1'b0;
    endtask

    task automatic ar_issue(input logic [31:0] a, input logic [4:0] d);
        int n;
        araddr           = a;
        cfg_rvalid_delay = d;
        arvalid          = 1'b1;
        n                = 0;
        @(negedge aclk);
        while (!arready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        chk("ar_accept_wait", 32'(n < 50), 32'd1);
        step();
        arvalid = 1'b0;
    endtask

    task automatic wait_rvalid(output int l);
        l = 1;
        @(negedge aclk);
        while (!rvalid && l < 60) begin
            step();
            l++;
            @(negedge aclk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        areset = 1'b1; arvalid = 1'b0; araddr = '0; arprot = 3'b010; rready = 1'b0;
        cfg_rvalid_delay = '0; load_en = 1'b0; load_addr = '0; load_data = '0;
        arvalid0 = 1'b0; rready0 = 1'b0;
        repeat (3) step();
        areset = 1'b0;
        @(negedge aclk);
        chk("reset_rvalid", 32'(rvalid), 32'd0);
        chk("reset_arready", 32'(arready), 32'd1);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_rresp", 32'(rresp), 32'd0);
        chk("reset_read_count", 32'(read_count), 32'd0);
        chk("reset_timeout_err", 32'(timeout_err), 32'd0);
        chk("reset_arready_dr0", 32'(arready0), 32'd0);
        chk("reset_rvalid_dr0", 32'(rvalid0), 32'd0);
        step();

        load(6'd0, 32'hA5A5A5A5);
        load(6'd4, 32'hDEADBEEF);
        load(6'd5, 32'h11111111);
        load(6'd8, 32'hCAFEF00D);
        load(6'd63, 32'h0F0F1234);

        // Zero-delay read
        rready = 1'b1;
        ar_issue(32'h10, 5'd0);
        wait_rvalid(lat);
        chk("d0_latency", 32'(lat), 32'd1);
        chk("d0_rdata", rdata, 32'hDEADBEEF);
        chk("d0_rresp", 32'(rresp), 32'd0);
        step();
        @(negedge aclk);
        chk("d0_rvalid_drop", 32'(rvalid), 32'd0);
        chk("d0_read_count", 32'(read_count), 32'd1);
        step();

        // Delay 5 with a 3-cycle stall
        rready = 1'b0;
        ar_issue(32'h20, 5'd5);
        wait_rvalid(lat);
        chk("d5_latency", 32'(lat), 32'd6);
        chk("d5_rdata", rdata, 32'hCAFEF00D);
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge aclk);
            chk("stall_rvalid", 32'(rvalid), 32'd1);
            chk("stall_rdata", rdata, 32'hCAFEF00D);
            chk("stall_rresp", 32'(rresp), 32'd0);
        end
        step();
        rready = 1'b1;
        step();
        @(negedge aclk);
        chk("d5_rvalid_drop", 32'(rvalid), 32'd0);
        chk("d5_read_count", 32'(read_count), 32'd2);
        step();

        // Illegal addresses: below minimum, misaligned, above maximum
        for (int i = 0; i < 3; i++) begin
            ar_issue((i == 0) ? 32'h0 : (i == 1) ? 32'h13 : 32'h100, 5'd0);
            wait_rvalid(lat);
            chk("err_rresp", 32'(rresp), 32'd2);
            chk("err_rdata", rdata, 32'd0);
            step();
        end

        // Highest legal word
        ar_issue(32'hFC, 5'd1);
        wait_rvalid(lat);
        chk("max_latency", 32'(lat), 32'd2);
        chk("max_rdata", rdata, 32'h0F0F1234);
        chk("max_rresp", 32'(rresp), 32'd0);
        step();

        // Load in the handshake cycle and during DELAY must not disturb the read
        araddr = 32'h14; cfg_rvalid_delay = 5'd2; arvalid = 1'b1;
        load_en = 1'b1; load_addr = 6'd5; load_data = 32'h22222222;
        step();
        arvalid = 1'b0; load_data = 32'h33333333;
        step();
        load_en = 1'b0;
        @(negedge aclk);
        chk("coll_rvalid_early", 32'(rvalid), 32'd0);
        step();
        @(negedge aclk);
        chk("coll_rvalid", 32'(rvalid), 32'd1);
        chk("coll_old_rdata", rdata, 32'h11111111);
        step();
        ar_issue(32'h14, 5'd0);
        wait_rvalid(lat);
        chk("coll_new_rdata", rdata, 32'h33333333);
        step();

        // arvalid held through a busy read is accepted only back in IDLE
        araddr = 32'h14; cfg_rvalid_delay = 5'd3; arvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            chk("busy_arready", 32'(arready), 32'(i == 0 || i == 5));
            chk("busy_rvalid", 32'(rvalid), 32'(i == 4 || i == 9));
            step();
        end
        arvalid = 1'b0;
        @(negedge aclk);
        chk("busy_read_count", 32'(read_count), 32'd10);
        step();

        // rready timeout
        rready = 1'b0;
        ar_issue(32'h10, 5'd0);
        for (int i = 0; i < 31; i++) step();
        @(negedge aclk);
        chk("timeout_31", 32'(timeout_err), 32'd0);
        step();
        @(negedge aclk);
        chk("timeout_32", 32'(timeout_err), 32'(TO_EN));
        step();
        rready = 1'b1;
        step();
        @(negedge aclk);
        chk("timeout_rvalid_drop", 32'(rvalid), 32'd0);
        chk("timeout_sticky", 32'(timeout_err), 32'(TO_EN));
        chk("timeout_read_count", 32'(read_count), 32'd11);
        step();

        // Reset in DELAY abandons the read, keeps the array
        ar_issue(32'h20, 5'd5);
        step();
        areset = 1'b1;
        step();
        areset = 1'b0;
        @(negedge aclk);
        chk("rst_delay_rvalid", 32'(rvalid), 32'd0);
        chk("rst_delay_arready", 32'(arready), 32'd1);
        chk("rst_delay_count", 32'(read_count), 32'd0);
        chk("rst_delay_timeout", 32'(timeout_err), 32'd0);
        chk("rst_delay_rdata", rdata, 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            @(negedge aclk);
            chk("rst_no_resp", 32'(rvalid), 32'd0);
        end
        step();
        ar_issue(32'h10, 5'd0);
        wait_rvalid(lat);
        chk("rst_mem_kept", rdata, 32'hDEADBEEF);
        step();
        @(negedge aclk);
        chk("rst_read_count", 32'(read_count), 32'd1);
        step();

        // DEFAULT_READY=0 instance: one-cycle arready pulse, stall while busy
        araddr = 32'h10; cfg_rvalid_delay = 5'd0; rready0 = 1'b0; arvalid0 = 1'b1;
        @(negedge aclk);
        chk("dr0_arready_first", 32'(arready0), 32'd0);
        step();
        @(negedge aclk);
        chk("dr0_arready_pulse", 32'(arready0), 32'd1);
        step();
        @(negedge aclk);
        chk("dr0_arready_drop", 32'(arready0), 32'd0);
        chk("dr0_rvalid", 32'(rvalid0), 32'd1);
        chk("dr0_rdata", rdata0, 32'hDEADBEEF);
        chk("dr0_rresp", 32'(rresp0), 32'd0);
        step();
        @(negedge aclk);
        chk("dr0_stalled_arready", 32'(arready0), 32'd0);
        chk("dr0_stalled_rvalid", 32'(rvalid0), 32'd1);
        step();
        rready0 = 1'b1;
        step();
        rready0 = 1'b0;
        @(negedge aclk);
        chk("dr0_rvalid_drop", 32'(rvalid0), 32'd0);
        chk("dr0_idle_arready", 32'(arready0), 32'd0);
        chk("dr0_read_count", 32'(read_count0), 32'd1);
        chk("dr0_timeout_err", 32'(timeout_err0), 32'd0);
        step();
        @(negedge aclk);
        chk("dr0_second_pulse", 32'(arready0), 32'd1);
        step();
        arvalid0 = 1'b0;
        rready0  = 1'b1;
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
